mode_power_ctrl: RTL
====================

# mode_power_ctrl

Multi-channel, parametrised successor to the single-channel mode/power decoder. It accepts per-channel configuration words over a valid/ready handshake and holds a mode bit and a target power level per channel. Each channel's output power ramps one step at a time toward its target at a programmable rate, so power changes stay slew-limited. It sits between the configuration source and the channel drivers, and reports a per-channel settled flag.

## Interface
- NUM_CH, 4, number of channels (≥1, need not be a power of 2)
- PWR_W, 4, power level width
- RAMP_DIV, 4, clock cycles per power step (≥1)
- CH_W (localparam), max(1, $clog2(NUM_CH)), channel index width
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- conf_valid  in  1  configuration word present
- conf_ready  out  1  block can accept a word
- conf_ch  in  CH_W  target channel index
- conf_mode  in  1  1 = on, 0 = standby
- conf_power  in  PWR_W  requested power level
- chs_power  out  NUM_CH*PWR_W  current power; channel i at [i*PWR_W +: PWR_W]
- chs_mode  out  NUM_CH  current mode per channel
- chs_settled  out  NUM_CH  1 when the channel's power equals its target
- conf_err  out  1  one-cycle pulse when an accepted word is dropped

## Operation
- **Reset values:**
  - all chs_power 0, chs_mode 0, targets 0, chs_settled all 1
  - conf_ready 1, conf_err 0, prescalers 0, pending register empty
- **Handshake:**
  - A word is accepted on an edge where conf_valid && conf_ready.
  - The word goes into a one-deep pending register.
  - conf_ready = !pending_valid (combinational).
  - The pending word is applied on the next edge and the register empties, so sustained throughput is one word per 2 cycles.
- **Apply, with conf_ch < NUM_CH:**
  - chs_mode[ch] ← conf_mode.
  - Target ← conf_mode ? conf_power : 0.
  - The channel's prescaler clears to 0. This happens on every apply, even when the target is unchanged.
- **Apply, with conf_ch ≥ NUM_CH:** no state changes; conf_err = 1 for exactly the cycle after the apply edge.
- **Per-channel FSM,** states SETTLED, UP, DOWN, decided each cycle by comparing power to target:
  - SETTLED: power == target. Prescaler is held at 0.
  - UP / DOWN: prescaler counts 0..RAMP_DIV-1. On terminal count, power moves ±1 toward target and the prescaler wraps to 0.
  - A retarget mid-ramp reverses direction from the current power. No overshoot; power never leaves [0, 2^PWR_W-1].
- chs_settled[i] = (state == SETTLED), registered together with power.
- Standby (mode 0) drops the mode bit immediately. Power ramps down to 0; it is not cut abruptly.
- Channels ramp independently and concurrently.

## Timing
- Accept edge N → apply edge N+1: chs_mode and chs_settled update after N+1, and conf_ready reads 1 again after N+1.
- First power step at edge N+1+RAMP_DIV; each further step RAMP_DIV cycles later.
- Full-scale ramp takes (2^PWR_W-1)·RAMP_DIV cycles after apply (60 at defaults).
- chs_settled rises on the same edge the final step lands.
- Reset asserted mid-ramp: all outputs return to reset values immediately (asynchronous). Any pending word is discarded.
- conf_valid with conf_ready low: the word is not accepted. The source must hold it.

## Structure
- **Package mode_power_pkg** holds:
  - the ramp state enum (SETTLED, UP, DOWN)
  - the default parameter constants
  - a function computing CH_W
- **Sub-module mode_power_channel** holds target, power, prescaler and FSM for one channel.
  - Inputs: apply strobe, mode, power.
  - Instantiate NUM_CH copies in a generate loop.
- The top level holds the pending register, address decode, conf_err and the output packing.

## Test plan
- **Reset:** after rst pulse → chs_power 0, chs_mode 0, chs_settled 4'b1111, conf_ready 1, conf_err 0.
- **Ramp up:** accept ch0, mode 1, power 9 at edge N (RAMP_DIV 4) →
  - chs_mode[0] = 1 after N+1
  - chs_power[0] = 1 at N+5, 9 at N+37
  - chs_settled[0] rises at N+37
- **Retarget mid-ramp:** while ch1 is at 6 heading to 12, send ch1 power 3 → ramps down to 3, one step per 4 cycles after apply, never exceeds 7.
- **Standby:** ch2 settled at 15, send mode 0 power 15 → chs_mode[2] = 0 after the apply edge; power reaches 0 exactly 60 cycles after apply.
- **Back-to-back:** conf_valid held high for words to ch0 and ch3 → conf_ready sequence 1, 0, 1; both channels apply on consecutive apply edges 2 cycles apart.
- **Errors and reset:**
  - NUM_CH = 3, conf_ch = 3 → conf_err high for one cycle, no channel changes.
  - rst asserted mid-ramp → outputs return to reset values immediately.

Source files
------------

// File: rtl/mode_power_pkg.sv
// Shared types and constants for the multi-channel mode/power controller.
// Ramp state, default sizing and width helpers.
package mode_power_pkg;

  typedef enum logic [1:0] {
    SETTLED = 2'd0,
    UP      = 2'd1,
    DOWN    = 2'd2
  } ramp_state_e;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_PWR_W    = 4;
  localparam int DEF_RAMP_DIV = 4;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int presc_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/mode_power_channel.sv
// One channel: mode bit, target, slew-limited power and ramp FSM.
// Power moves one step per RAMP_DIV cycles toward the target.
module mode_power_channel
  import mode_power_pkg::*;
#(
  parameter int PWR_W    = DEF_PWR_W,
  parameter int RAMP_DIV = DEF_RAMP_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             apply,
  input  logic             cfg_mode,
  input  logic [PWR_W-1:0] cfg_power,
  output logic             mode,
  output logic [PWR_W-1:0] power,
  output logic             settled
);

  localparam int PS_W = presc_width(RAMP_DIV);
  localparam logic [PS_W-1:0] PS_TC = PS_W'(RAMP_DIV - 1);

  ramp_state_e      state_q, state_d;
  logic             mode_q, mode_d;
  logic [PWR_W-1:0] target_q, target_d;
  logic [PWR_W-1:0] power_q, power_d;
  logic [PS_W-1:0]  presc_q, presc_d;
  logic             tc;

  assign tc = (presc_q == PS_TC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SETTLED;
      mode_q   <= 1'b0;
      target_q <= '0;
      power_q  <= '0;
      presc_q  <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      target_q <= target_d;
      power_q  <= power_d;
      presc_q  <= presc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    target_d = target_q;
    power_d  = power_q;
    presc_d  = presc_q;
    if (apply) begin
      mode_d   = cfg_mode;
      target_d = cfg_mode ? cfg_power : '0;
      presc_d  = '0;
    end else begin
      unique case (state_q)
        UP: begin
          if (tc) begin
            power_d = power_q + 1'b1;
            presc_d = '0;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        DOWN: begin
          if (tc) begin
            power_d = power_q - 1'b1;
            presc_d = '0;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        default: presc_d = '0;
      endcase
    end
    // direction is re-decided from the values landing this edge
    unique case (1'b1)
      (power_d == target_d): state_d = SETTLED;
      (power_d < target_d):  state_d = UP;
      default:               state_d = DOWN;
    endcase
  end

  assign mode    = mode_q;
  assign power   = power_q;
  assign settled = (state_q == SETTLED);

endmodule

// File: rtl/mode_power_ctrl.sv
// Multi-channel mode/power controller: one-deep config buffer,
// channel decode, error pulse and packing of per-channel outputs.
module mode_power_ctrl
  import mode_power_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int PWR_W    = DEF_PWR_W,
  parameter int RAMP_DIV = DEF_RAMP_DIV,
  localparam int CH_W    = ch_width(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    conf_valid,
  output logic                    conf_ready,
  input  logic [CH_W-1:0]         conf_ch,
  input  logic                    conf_mode,
  input  logic [PWR_W-1:0]        conf_power,
  output logic [NUM_CH*PWR_W-1:0] chs_power,
  output logic [NUM_CH-1:0]       chs_mode,
  output logic [NUM_CH-1:0]       chs_settled,
  output logic                    conf_err
);

  logic             pend_valid;
  logic [CH_W-1:0]  pend_ch;
  logic             pend_mode;
  logic [PWR_W-1:0] pend_power;
  logic             accept;
  logic             pend_bad;

  assign conf_ready = !pend_valid;
  assign accept     = conf_valid && conf_ready;
  assign pend_bad   = (32'(pend_ch) >= NUM_CH);

  // accept only happens when empty, so a full buffer always drains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_ch    <= '0;
      pend_mode  <= 1'b0;
      pend_power <= '0;
      conf_err   <= 1'b0;
    end else begin
      pend_valid <= accept;
      conf_err   <= pend_valid && pend_bad;
      if (accept) begin
        pend_ch    <= conf_ch;
        pend_mode  <= conf_mode;
        pend_power <= conf_power;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic apply;

    assign apply = pend_valid && (32'(pend_ch) == i);

    mode_power_channel #(
      .PWR_W    (PWR_W),
      .RAMP_DIV (RAMP_DIV)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .apply     (apply),
      .cfg_mode  (pend_mode),
      .cfg_power (pend_power),
      .mode      (chs_mode[i]),
      .power     (chs_power[i*PWR_W +: PWR_W]),
      .settled   (chs_settled[i])
    );
  end

endmodule
